// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, control encodings, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        COMMIT = 2'd2,
        TRAP   = 2'd3
    } state_t;

    // Decoded control set; reg_write/mem_write/branch are intents that the
    // sequencer only turns into strobes during COMMIT.
    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_control;
        logic [1:0] imm_src;
        logic       result_src;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/instr_sequencer_main_decoder.sv
// Combinational main decoder: instruction word to static controls plus illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the instruction bus.
module main_decoder
    import seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instruccion,
    output ctrl_t           ctrl,
    output logic            is_illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;

    assign opcode   = instruccion[6:0];
    assign funct3   = instruccion[14:12];
    assign funct7_5 = instruccion[30];

    // Register/immediate fields are consumed by the datapath, not here.
    logic unused_fields;
    assign unused_fields = &{1'b0, instruccion[XLEN-1:31], instruccion[29:15], instruccion[11:7]};

    // Decode table; anything not matched falls through as illegal with zero controls.
    always_comb begin
        ctrl       = '0;
        is_illegal = 1'b1;
        case (opcode)
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    ctrl.alu_src     = 1'b1;
                    ctrl.imm_src     = IMM_I;
                    ctrl.alu_control = ALU_ADD;
                    ctrl.result_src  = 1'b1;
                    ctrl.reg_write   = 1'b1;
                    is_illegal       = 1'b0;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    ctrl.alu_src     = 1'b1;
                    ctrl.imm_src     = IMM_S;
                    ctrl.alu_control = ALU_ADD;
                    ctrl.mem_write   = 1'b1;
                    is_illegal       = 1'b0;
                end
            end
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                is_illegal     = 1'b0;
                case (funct3)
                    3'b000:  ctrl.alu_control = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b111:  ctrl.alu_control = ALU_AND;
                    3'b110:  ctrl.alu_control = ALU_OR;
                    default: begin
                        ctrl.reg_write = 1'b0;
                        is_illegal     = 1'b1;
                    end
                endcase
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    ctrl.imm_src     = IMM_B;
                    ctrl.alu_control = ALU_SUB;
                    ctrl.branch      = 1'b1;
                    is_illegal       = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: latches one instruction, decodes it, commits it in a fixed 3-cycle FSM.
// Latency: accept at edge N -> DECODE in N+1, COMMIT in N+2, instr_ready again in N+3.
// Backpressure: instr_ready high only in IDLE after reset; INSTR_COUNT_EN adds retired_count.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit ILL_STICKY = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instr_in,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] instruccion,
    output logic            PCSrc,
    output logic            ResultSrc,
    output logic            MemWrite,
    output logic            ALUSrc,
    output logic            RegWrite,
    output logic [1:0]      ALUControl,
    output logic [1:0]      ImmSrc,
    output logic            pc_en,
    output logic            illegal
`ifdef INSTR_COUNT_EN
    ,
    output logic [31:0]     retired_count
`endif
);

    state_t state;
    state_t state_nxt;
    logic   ready_en;
    logic   accept;
    ctrl_t  dec_ctrl;
    logic   dec_illegal;

    main_decoder #(.XLEN(XLEN)) u_main_decoder (
        .instruccion (instruccion),
        .ctrl        (dec_ctrl),
        .is_illegal  (dec_illegal)
    );

    assign accept = instr_valid && instr_ready;

    // State, instruction latch and the post-reset ready enable (keeps ready low until the first edge after release).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready_en    <= 1'b0;
            instruccion <= '0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            if (accept) begin
                instruccion <= instr_in;
            end
        end
    end

    // Next-state: fixed IDLE->DECODE->COMMIT walk, diverting to TRAP on illegal decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DECODE;
            DECODE:  state_nxt = dec_illegal ? TRAP : COMMIT;
            COMMIT:  state_nxt = IDLE;
            TRAP:    state_nxt = ILL_STICKY ? TRAP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: static controls in DECODE/COMMIT, one-cycle strobes only in COMMIT.
    always_comb begin
        instr_ready = ready_en && (state == IDLE);
        PCSrc       = 1'b0;
        ResultSrc   = 1'b0;
        MemWrite    = 1'b0;
        ALUSrc      = 1'b0;
        RegWrite    = 1'b0;
        ALUControl  = 2'b00;
        ImmSrc      = 2'b00;
        pc_en       = 1'b0;
        illegal     = 1'b0;
        case (state)
            DECODE: begin
                ALUSrc     = dec_ctrl.alu_src;
                ALUControl = dec_ctrl.alu_control;
                ImmSrc     = dec_ctrl.imm_src;
                ResultSrc  = dec_ctrl.result_src;
            end
            COMMIT: begin
                ALUSrc     = dec_ctrl.alu_src;
                ALUControl = dec_ctrl.alu_control;
                ImmSrc     = dec_ctrl.imm_src;
                ResultSrc  = dec_ctrl.result_src;
                RegWrite   = dec_ctrl.reg_write;
                MemWrite   = dec_ctrl.mem_write;
                PCSrc      = dec_ctrl.branch && (alu_result == '0);
                pc_en      = 1'b1;
            end
            TRAP:    illegal = 1'b1;
            default: ;
        endcase
    end

`ifdef INSTR_COUNT_EN
    // Retired-instruction counter: one per COMMIT cycle, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= '0;
        end else if (state == COMMIT) begin
            retired_count <= retired_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, add/sw/beq/illegal, back-to-back stream with mid-commit reset.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Retired-count checks are compiled in only when INSTR_COUNT_EN is defined.
module tb_instr_sequencer;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h402081B3;
    localparam logic [31:0] I_OR  = 32'h0020E1B3;
    localparam logic [31:0] I_LW  = 32'h0080A183;
    localparam logic [31:0] I_SW  = 32'h0020A423;
    localparam logic [31:0] I_BEQ = 32'h00208863;
    localparam logic [31:0] I_ILL = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] alu_result;
    logic [31:0] instruccion;
    logic        PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, pc_en, illegal;
    logic [1:0]  ALUControl, ImmSrc;
`ifdef INSTR_COUNT_EN
    logic [31:0] retired_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    instr_sequencer #(.XLEN(32), .ILL_STICKY(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_result  (alu_result),
        .instruccion (instruccion),
        .PCSrc       (PCSrc),
        .ResultSrc   (ResultSrc),
        .MemWrite    (MemWrite),
        .ALUSrc      (ALUSrc),
        .RegWrite    (RegWrite),
        .ALUControl  (ALUControl),
        .ImmSrc      (ImmSrc),
        .pc_en       (pc_en),
        .illegal     (illegal)
`ifdef INSTR_COUNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in IDLE and let it be accepted on the next edge.
    task automatic accept_instr(input logic [31:0] ins);
        instr_in    = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr_in    = 32'hDEADBEEF;
    endtask

    task automatic test_reset();
        logic [12:0] outs;
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instr_in    = I_ADD;
        alu_result  = '0;
        repeat (3) tick();
        outs = {PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, ALUControl, ImmSrc, pc_en, illegal, 2'b00};
        n_checks++; if (instr_ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", instr_ready); else n_pass++;
        n_checks++; if (outs !== 13'd0) $display("FAIL reset_outputs got=%h exp=0", outs); else n_pass++;
        n_checks++; if (instruccion !== 32'd0) $display("FAIL reset_instr got=%h exp=0", instruccion); else n_pass++;
`ifdef INSTR_COUNT_EN
        n_checks++; if (retired_count !== 32'd0) $display("FAIL reset_count got=%0d exp=0", retired_count); else n_pass++;
`endif
        rst_n       = 1'b1;
        instr_valid = 1'b0;
        #1;
        n_checks++; if (instr_ready !== 1'b0) $display("FAIL release_ready_early got=%0b exp=0", instr_ready); else n_pass++;
        tick();
        n_checks++; if (instr_ready !== 1'b1) $display("FAIL release_ready got=%0b exp=1", instr_ready); else n_pass++;
    endtask

    task automatic test_add();
        alu_result = '0;
        accept_instr(I_ADD);
        n_checks++; if (instruccion !== I_ADD) $display("FAIL add_latch got=%h exp=%h", instruccion, I_ADD); else n_pass++;
        n_checks++; if ({ALUSrc, ALUControl} !== 3'b000) $display("FAIL add_decode got=%b exp=000", {ALUSrc, ALUControl}); else n_pass++;
        n_checks++; if ({RegWrite, pc_en, instr_ready} !== 3'b000) $display("FAIL add_decode_strobes got=%b exp=000", {RegWrite, pc_en, instr_ready}); else n_pass++;
        tick();
        n_checks++; if ({RegWrite, pc_en, MemWrite, PCSrc} !== 4'b1100) $display("FAIL add_commit got=%b exp=1100", {RegWrite, pc_en, MemWrite, PCSrc}); else n_pass++;
        tick();
        n_checks++; if ({instr_ready, RegWrite, pc_en} !== 3'b100) $display("FAIL add_after got=%b exp=100", {instr_ready, RegWrite, pc_en}); else n_pass++;
    endtask

    task automatic test_sw();
        accept_instr(I_SW);
        n_checks++; if ({ImmSrc, ALUSrc, MemWrite, RegWrite} !== 5'b01100) $display("FAIL sw_decode got=%b exp=01100", {ImmSrc, ALUSrc, MemWrite, RegWrite}); else n_pass++;
        tick();
        n_checks++; if ({MemWrite, RegWrite, pc_en, ResultSrc} !== 4'b1010) $display("FAIL sw_commit got=%b exp=1010", {MemWrite, RegWrite, pc_en, ResultSrc}); else n_pass++;
        tick();
        n_checks++; if ({instr_ready, MemWrite, RegWrite} !== 3'b100) $display("FAIL sw_after got=%b exp=100", {instr_ready, MemWrite, RegWrite}); else n_pass++;
    endtask

    task automatic test_beq();
        alu_result = 32'd0;
        accept_instr(I_BEQ);
        n_checks++; if ({ImmSrc, ALUControl, ALUSrc, PCSrc, pc_en} !== 7'b1001000) $display("FAIL beq_decode got=%b exp=1001000", {ImmSrc, ALUControl, ALUSrc, PCSrc, pc_en}); else n_pass++;
        tick();
        n_checks++; if ({PCSrc, pc_en, RegWrite, MemWrite} !== 4'b1100) $display("FAIL beq_taken got=%b exp=1100", {PCSrc, pc_en, RegWrite, MemWrite}); else n_pass++;
        tick();
        alu_result = 32'd5;
        accept_instr(I_BEQ);
        tick();
        n_checks++; if ({PCSrc, pc_en} !== 2'b01) $display("FAIL beq_not_taken got=%b exp=01", {PCSrc, pc_en}); else n_pass++;
        tick();
        n_checks++; if ({instr_ready, PCSrc, pc_en} !== 3'b100) $display("FAIL beq_after got=%b exp=100", {instr_ready, PCSrc, pc_en}); else n_pass++;
    endtask

    task automatic test_illegal();
        int bad = 0;
        accept_instr(I_ILL);
        instr_valid = 1'b1;
        instr_in    = I_ADD;
        n_checks++; if ({illegal, instr_ready, pc_en} !== 3'b000) $display("FAIL ill_decode got=%b exp=000", {illegal, instr_ready, pc_en}); else n_pass++;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (illegal !== 1'b1 || instr_ready !== 1'b0 || pc_en !== 1'b0 || RegWrite !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (bad !== 0) $display("FAIL ill_sticky bad_cycles got=%0d exp=0", bad); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (illegal !== 1'b0) $display("FAIL ill_reset got=%0b exp=0", illegal); else n_pass++;
        instr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if ({instr_ready, illegal} !== 2'b10) $display("FAIL ill_recover got=%b exp=10", {instr_ready, illegal}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int strobes = 0;
        instr_in    = I_LW;
        instr_valid = 1'b1;
        if (instr_ready && instr_valid) acc++;
        tick();
        instr_in = I_SUB;
        if (instr_ready && instr_valid) acc++;
        n_checks++; if ({ResultSrc, ALUSrc, ALUControl} !== 4'b1100) $display("FAIL b2b_lw_decode got=%b exp=1100", {ResultSrc, ALUSrc, ALUControl}); else n_pass++;
        tick();
        if (instr_ready && instr_valid) acc++;
        n_checks++; if ({RegWrite, pc_en, ResultSrc} !== 3'b111) $display("FAIL b2b_lw_commit got=%b exp=111", {RegWrite, pc_en, ResultSrc}); else n_pass++;
        tick();
        if (instr_ready && instr_valid) acc++;
        tick();
        if (instr_ready && instr_valid) acc++;
        n_checks++; if ({instruccion, ALUControl} !== {I_SUB, 2'b01}) $display("FAIL b2b_sub_decode got=%h/%b exp=%h/01", instruccion, ALUControl, I_SUB); else n_pass++;
        tick();
        if (instr_ready && instr_valid) acc++;
        n_checks++; if ({RegWrite, pc_en} !== 2'b11) $display("FAIL b2b_sub_commit got=%b exp=11", {RegWrite, pc_en}); else n_pass++;
        n_checks++; if (acc !== 2) $display("FAIL b2b_accept_rate got=%0d exp=2", acc); else n_pass++;
`ifdef INSTR_COUNT_EN
        n_checks++; if (retired_count !== 32'd1) $display("FAIL b2b_count_pre got=%0d exp=1", retired_count); else n_pass++;
`endif
        rst_n = 1'b0;
        #1;
        n_checks++; if ({RegWrite, pc_en, MemWrite, instr_ready} !== 4'b0000) $display("FAIL b2b_reset_drop got=%b exp=0000", {RegWrite, pc_en, MemWrite, instr_ready}); else n_pass++;
`ifdef INSTR_COUNT_EN
        n_checks++; if (retired_count !== 32'd0) $display("FAIL b2b_count_post got=%0d exp=0", retired_count); else n_pass++;
`endif
        instr_in = I_OR;
        for (int i = 0; i < 2; i++) begin
            if (RegWrite !== 1'b0 || pc_en !== 1'b0) strobes++;
            tick();
        end
        rst_n = 1'b1;
        tick();
        if (RegWrite !== 1'b0 || pc_en !== 1'b0) strobes++;
        n_checks++; if (strobes !== 0) $display("FAIL b2b_no_double_commit got=%0d exp=0", strobes); else n_pass++;
        n_checks++; if (instr_ready !== 1'b1) $display("FAIL b2b_ready_after_reset got=%0b exp=1", instr_ready); else n_pass++;
        tick();
        n_checks++; if ({ALUControl, ALUSrc} !== 3'b110) $display("FAIL b2b_or_decode got=%b exp=110", {ALUControl, ALUSrc}); else n_pass++;
        instr_valid = 1'b0;
        tick();
        n_checks++; if ({RegWrite, pc_en} !== 2'b11) $display("FAIL b2b_or_commit got=%b exp=11", {RegWrite, pc_en}); else n_pass++;
        tick();
`ifdef INSTR_COUNT_EN
        n_checks++; if (retired_count !== 32'd1) $display("FAIL b2b_count_or got=%0d exp=1", retired_count); else n_pass++;
`endif
        n_checks++; if (instr_ready !== 1'b1) $display("FAIL b2b_final_ready got=%0b exp=1", instr_ready); else n_pass++;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_in    = '0;
        alu_result  = '0;
        test_reset();
        test_add();
        test_sw();
        test_beq();
        test_illegal();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream control stage for the four-operation RISC-V datapath. It accepts 32-bit instructions over a valid/ready handshake and holds each one stable on the datapath instruction bus.
- Decodes each instruction into the datapath control set: PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, ALUControl, ImmSrc.
- Sequences every instruction through a fixed 3-cycle FSM, so that register-file, memory and PC updates happen on exactly one clock edge.

Parameters:
- XLEN, 32, instruction and ALU result width.
- ILL_STICKY, 1, 1 = an illegal opcode locks the FSM in TRAP until reset; 0 = skip the instruction and return to IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_in  in  XLEN  instruction from the fetch source.
- instr_valid  in  1  instr_in is valid.
- instr_ready  out  1  sequencer can accept an instruction.
- alu_result  in  XLEN  datapath ALU result, used to derive zero for beq.
- instruccion  out  XLEN  latched instruction driven to the datapath.
- PCSrc  out  1  select branch target.
- ResultSrc  out  1  0 = ALU result, 1 = memory read data.
- MemWrite  out  1  data memory write strobe.
- ALUSrc  out  1  0 = register operand, 1 = immediate.
- RegWrite  out  1  register-file write strobe.
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 or.
- ImmSrc  out  2  00 I, 01 S, 10 B.
- pc_en  out  1  PC register load enable; the PC register loads only while pc_en=1.
- illegal  out  1  unsupported opcode or funct detected.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; instruccion=0.
  - All control outputs 0 and illegal=0.
  - instr_ready=0 while rst_n=0, and 1 from the first edge after release.
- Reset mid-instruction aborts it with no RegWrite, MemWrite or pc_en pulse.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch instr_in into instruccion and go to DECODE.
  - All strobes are 0.
- DECODE (1 cycle):
  - instr_ready=0.
  - Drive the static controls ALUSrc, ALUControl, ImmSrc and ResultSrc from the opcode and funct fields.
  - RegWrite, MemWrite and pc_en stay 0.
  - Next state is COMMIT, or TRAP if the instruction is illegal.
- COMMIT (1 cycle):
  - Static controls are held.
  - Assert for exactly one cycle: pc_en=1, RegWrite for lw and R-type, MemWrite for sw.
  - PCSrc=1 only for beq with alu_result==0; otherwise PCSrc=0.
  - Next state is IDLE.
- Throughput: 1 instruction per 3 cycles. Acceptance at edge N gives DECODE in cycle N+1, COMMIT in N+2, and instr_ready=1 again in N+3.
- Decode table (opcode / funct3 / funct7[5]):
  - lw, 0000011 / 010: ALUSrc=1, ImmSrc=00, ALUControl=00, ResultSrc=1, RegWrite.
  - sw, 0100011 / 010: ALUSrc=1, ImmSrc=01, ALUControl=00, MemWrite.
  - R-type, 0110011:
    - add: funct3 000, funct7[5]=0 → ALUControl=00.
    - sub: funct3 000, funct7[5]=1 → ALUControl=01.
    - and: funct3 111 → ALUControl=10.
    - or: funct3 110 → ALUControl=11.
    - All R-type: ALUSrc=0, RegWrite.
  - beq, 1100011 / 000: ALUSrc=0, ImmSrc=10, ALUControl=01.
  - Any other combination is illegal.
- TRAP:
  - illegal=1; all strobes 0; instr_ready=0.
  - With ILL_STICKY=1 the FSM stays in TRAP until reset.
  - With ILL_STICKY=0 illegal is held for 1 cycle, then the FSM returns to IDLE with no pc_en (the instruction is dropped).
- While not in IDLE, instr_valid is ignored and instr_in may change freely.
- alu_result is sampled only in COMMIT. A zero result on a non-beq instruction has no effect.

Optional Feature:
- INSTR_COUNT_EN defined:
  - Adds output retired_count (32 bits), reset to 0.
  - Increments on every COMMIT cycle and wraps from 0xFFFFFFFF to 0.
  - Dropped or illegal instructions are not counted.
- INSTR_COUNT_EN undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package seq_pkg holds:
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH.
  - ALU_ADD, ALU_SUB, ALU_AND, ALU_OR and IMM_I, IMM_S, IMM_B.
  - State enum IDLE, DECODE, COMMIT, TRAP.
- One combinational sub-module, main_decoder: takes instruccion and outputs the static controls plus is_illegal. The FSM and strobes stay in instr_sequencer.

Test Plan:
- Reset: hold rst_n=0 with instr_valid=1 → instr_ready=0, all outputs 0. After release, instr_ready=1 one cycle later.
- add x3,x1,x2 (0x002081B3) → DECODE: ALUSrc=0, ALUControl=00. COMMIT: RegWrite=1 and pc_en=1 for exactly 1 cycle. instr_ready=1 again 3 cycles after acceptance.
- sw x2,8(x1) (0x0020A423) → ImmSrc=01, ALUSrc=1, MemWrite=1 only in COMMIT, RegWrite=0 throughout.
- beq x1,x2,+16 (0x00208863):
  - with alu_result=0 → PCSrc=1 and pc_en=1 in COMMIT.
  - repeated with alu_result=5 → PCSrc=0.
- Illegal 0x00000013 (addi, unsupported) with ILL_STICKY=1 → illegal=1 and instr_ready stays 0 for 20 cycles. rst_n pulse clears it.
- Back-to-back lw/sub/or stream with instr_valid held high; reset asserted during a sub COMMIT cycle:
  - before reset: exactly 1 acceptance per 3 cycles;
  - at reset: the strobe drops asynchronously, no double commit;
  - with INSTR_COUNT_EN: retired_count=1 before reset, 0 after.
